// File: rtl/clock_pkg.sv
// Shared clock-core display definitions: shifter states, default frame geometry, counter sizing.
package clock_pkg;

    localparam int DISPLAY_FRAME_BITS = 32;
    localparam int DISPLAY_CLK_DIV    = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        LATCH,
        DONE
    } shifter_state_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable CLK_DIV-cycle down-counter; phase_end_o rises in the last cycle of a loaded phase.
// No flow control: the owner reloads on the same cycle it consumes phase_end_o.
module phase_timer
    import clock_pkg::*;
#(
    parameter int CLK_DIV = DISPLAY_CLK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    output logic phase_end_o
);

    localparam int W = cnt_width(CLK_DIV);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(CLK_DIV - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Held high once exhausted; only meaningful in the phases that reload it.
    assign phase_end_o = (cnt_q == '0);

endmodule

// File: rtl/serial_display_shifter.sv
// Shifts one NUM_BITS frame MSB first onto serial_out/clk_out, then pulses latch_out; done after
// 2*CLK_DIV*NUM_BITS+CLK_DIV+1 cycles. start is ignored while busy or in the done cycle.
module serial_display_shifter
    import clock_pkg::*;
#(
    parameter int NUM_BITS = DISPLAY_FRAME_BITS,
    parameter int CLK_DIV  = DISPLAY_CLK_DIV
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [NUM_BITS-1:0] data_in,
    output logic                busy,
    output logic                done,
    output logic                serial_out,
    output logic                clk_out,
    output logic                latch_out
);

    localparam int BW = cnt_width(NUM_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);

    shifter_state_t      state_q;
    logic [NUM_BITS-1:0] shreg_q;
    logic [BW-1:0]       bit_cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                clk_out_q;
    logic                latch_q;

    logic phase_end;
    logic timer_load;

    // Every LOW, HIGH and LATCH phase starts with a fresh CLK_DIV count.
    always_comb begin
        timer_load = ((state_q == IDLE) && start) ||
                     (((state_q == LOW) || (state_q == HIGH)) && phase_end);
    end

    phase_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_phase_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (timer_load),
        .phase_end_o(phase_end)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clk_out_q <= 1'b0;
            latch_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg_q   <= data_in;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= LOW;
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        clk_out_q <= 1'b1;
                        state_q   <= HIGH;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        clk_out_q <= 1'b0;
                        if (bit_cnt_q == LAST_BIT) begin
                            latch_q <= 1'b1;
                            state_q <= LATCH;
                        end else begin
                            // Next bit lands on serial_out together with the falling clock.
                            shreg_q   <= shreg_q << 1;
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                            state_q   <= LOW;
                        end
                    end
                end
                LATCH: begin
                    if (phase_end) begin
                        latch_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The shift register MSB is the data pin, so it holds the last bit between frames.
    assign serial_out = shreg_q[NUM_BITS-1];
    assign busy       = busy_q;
    assign done       = done_q;
    assign clk_out    = clk_out_q;
    assign latch_out  = latch_q;

endmodule

// File: tb/tb_serial_display_shifter.sv
// Bench: two shifter instances (32 bits / div 4 and 8 bits / div 1) against a cycle-indexed frame model.
module tb_serial_display_shifter;

    localparam int NA = 32;
    localparam int CA = 4;
    localparam int NB = 8;
    localparam int CB = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  start = '0;
    logic [31:0] data_a = '0;
    logic [7:0]  data_b = '0;
    logic [1:0]  busy, done, ser, clko, lat;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_display_shifter #(.NUM_BITS(NA), .CLK_DIV(CA)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .data_in(data_a),
        .busy(busy[0]), .done(done[0]), .serial_out(ser[0]), .clk_out(clko[0]), .latch_out(lat[0])
    );

    serial_display_shifter #(.NUM_BITS(NB), .CLK_DIV(CB)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .data_in(data_b),
        .busy(busy[1]), .done(done[1]), .serial_out(ser[1]), .clk_out(clko[1]), .latch_out(lat[1])
    );

    task automatic check(input string name, input int inst, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, inst, got, exp, $time);
        end
    endtask

    // ---------------- behavioural frame model ----------------
    int          nbits [2] = '{NA, NB};
    int          cdiv  [2] = '{CA, CB};
    bit          m_act [2] = '{1'b0, 1'b0};
    int          m_k   [2] = '{0, 0};
    logic [31:0] m_d   [2] = '{32'd0, 32'd0};
    logic        m_last[2] = '{1'b0, 1'b0};

    function automatic int frame_len(input int i);
        return 2 * cdiv[i] * nbits[i] + cdiv[i] + 1;
    endfunction

    function automatic logic [31:0] din(input int i);
        return (i == 0) ? data_a : {24'd0, data_b};
    endfunction

    function automatic logic [31:0] frame_mask(input int i);
        logic [31:0] one = 32'd1;
        return (nbits[i] >= 32) ? 32'hFFFF_FFFF : ((one << nbits[i]) - 32'd1);
    endfunction

    // {busy, done, serial_out, clk_out, latch_out} for cycle m_k of the current frame.
    function automatic logic [4:0] expect_out(input int i);
        int k, n, c, p;
        if (!m_act[i]) return {1'b0, 1'b0, m_last[i], 1'b0, 1'b0};
        k = m_k[i];
        n = nbits[i];
        c = cdiv[i];
        if (k <= 2 * c * n) begin
            p = (k - 1) / c;
            return {1'b1, 1'b0, m_d[i][n - 1 - p / 2], ((p % 2) == 1), 1'b0};
        end
        if (k <= 2 * c * n + c) return {1'b1, 1'b0, m_d[i][0], 1'b0, 1'b1};
        return {1'b0, 1'b1, m_d[i][0], 1'b0, 1'b0};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_act[i]  = 1'b0;
                m_last[i] = 1'b0;
            end else if (m_act[i]) begin
                if (m_k[i] == frame_len(i)) begin
                    m_act[i]  = 1'b0;
                    m_last[i] = m_d[i][0];
                end else begin
                    m_k[i]++;
                end
            end else if (start[i]) begin
                m_act[i] = 1'b1;
                m_k[i]   = 1;
                m_d[i]   = din(i);
            end
        end
    end

    // ---------------- per-cycle compare + external chain model ----------------
    logic        prev_clk[2] = '{1'b0, 1'b0};
    logic        prev_ser[2] = '{1'b0, 1'b0};
    logic        prev_lat[2] = '{1'b0, 1'b0};
    int          stable[2] = '{0, 0};
    logic [31:0] chain[2] = '{32'd0, 32'd0};
    int          edges[2] = '{0, 0};
    int          latch_seen[2] = '{0, 0};
    int          done_seen[2] = '{0, 0};
    logic [31:0] latched[2] = '{32'd0, 32'd0};
    int          latched_edges[2] = '{0, 0};

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check("outputs{busy,done,ser,clk,latch}", i,
                      {59'd0, busy[i], done[i], ser[i], clko[i], lat[i]}, {59'd0, expect_out(i)});
                if (ser[i] == prev_ser[i]) stable[i]++;
                else stable[i] = 1;
                if (!reset_n) begin
                    edges[i] = 0;
                end else begin
                    if (clko[i] && !prev_clk[i]) begin
                        chain[i] = {chain[i][30:0], ser[i]};
                        edges[i]++;
                        check("setup_before_rise", i, stable[i] > cdiv[i], 1);
                    end
                    if (clko[i] && prev_clk[i]) check("hold_while_clk_high", i, ser[i], prev_ser[i]);
                    if (lat[i] && !prev_lat[i]) begin
                        latch_seen[i]++;
                        latched[i]       = chain[i] & frame_mask(i);
                        latched_edges[i] = edges[i];
                        check("latched_frame", i, latched[i], m_d[i] & frame_mask(i));
                        check("edges_per_latch", i, edges[i], nbits[i]);
                        edges[i] = 0;
                    end
                    if (done[i]) done_seen[i]++;
                end
                prev_clk[i] = clko[i];
                prev_ser[i] = ser[i];
                prev_lat[i] = lat[i];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [31:0] d);
        if (i == 0) data_a = d;
        else data_b = d[7:0];
    endtask

    // Accept one frame; report the cycle index of done and the latch_out width.
    task automatic run_frame(input int i, input logic [31:0] d, output int done_at, output int lat_cycles);
        int n;
        set_data(i, d);
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
        n = 1;
        lat_cycles = 0;
        while (!done[i] && n < 1000) begin
            if (lat[i]) lat_cycles++;
            tick();
            n++;
        end
        done_at = n;
        tick();
    endtask

    initial begin
        int da, lc, d0, ls, gaps, last_done, fa, fb, cyc;
        logic pb;

        // Reset
        #3 reset_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 2; i++)
            check("reset_outputs", i, {59'd0, busy[i], done[i], ser[i], clko[i], lat[i]}, 64'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Single frame, default geometry
        run_frame(0, 32'hA5C3_0F81, da, lc);
        check("done_latency", 0, da, 261);
        check("latch_width", 0, lc, 4);
        check("chain_frame", 0, latched[0], 64'hA5C3_0F81);
        check("edge_count", 0, latched_edges[0], 32);

        // CLK_DIV=1, 8-bit frame
        run_frame(1, 32'h0000_00B2, da, lc);
        check("done_latency", 1, da, 18);
        check("latch_width", 1, lc, 1);
        check("chain_frame", 1, latched[1], 64'hB2);
        check("edge_count", 1, latched_edges[1], 8);

        // start pulses while busy are ignored
        d0 = done_seen[0];
        data_a = 32'hFFFF_FFFF;
        start[0] = 1'b1;
        tick();
        for (int n = 1; n <= 300; n++) begin
            start[0] = (n == 10 || n == 100 || n == 258);
            data_a   = start[0] ? 32'd0 : $urandom;
            tick();
        end
        start[0] = 1'b0;
        check("single_done_pulse", 0, done_seen[0] - d0, 1);
        check("busy_start_frame", 0, latched[0], 64'hFFFF_FFFF);
        check("busy_start_edges", 0, latched_edges[0], 32);

        // Reset during the HIGH phase of bit 5 aborts without a latch pulse
        data_a = $urandom;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (45) tick();
        check("in_high_phase_bit5", 0, clko[0], 1);
        ls = latch_seen[0];
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            check("async_reset_outputs", i, {59'd0, busy[i], done[i], ser[i], clko[i], lat[i]}, 64'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (300) tick();
        check("busy_after_abort", 0, busy[0], 0);
        check("no_latch_after_abort", 0, latch_seen[0], ls);

        // Back-to-back frames with start held high
        gaps = 0;
        last_done = -1;
        pb = busy[0];
        start[0] = 1'b1;
        for (int n = 0; n < 1000 && gaps < 3; n++) begin
            if (done[0]) last_done = n;
            if (busy[0] && !pb && last_done >= 0) begin
                check("frame_gap", 0, n - last_done, 2);
                gaps++;
            end
            pb = busy[0];
            data_a = n[0] ? 32'h8765_4321 : 32'h1234_5678;
            tick();
        end
        start[0] = 1'b0;
        check("b2b_frames_seen", 0, gaps, 3);
        for (int n = 0; n < 600 && (busy[0] || done[0]); n++) tick();

        // Random run on both instances
        fa = done_seen[0];
        fb = done_seen[1];
        cyc = 0;
        while (cyc < 40000 && ((done_seen[0] - fa) < 60 || (done_seen[1] - fb) < 200)) begin
            start[0] = ($urandom_range(0, 3) == 0);
            start[1] = ($urandom_range(0, 3) == 0);
            data_a   = $urandom;
            data_b   = 8'($urandom);
            tick();
            cyc++;
        end
        start = '0;
        repeat (600) tick();
        check("random_frames_a", 0, (done_seen[0] - fa) >= 60, 1);
        check("random_frames_b", 1, (done_seen[1] - fb) >= 200, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
